// File: rtl/hist_peak_reader.sv
// Sweeps per-pixel histograms stored back-to-back in a read-only SRAM port and
// reports, for each pixel, the lowest-indexed bin holding the largest count.
module hist_peak_reader #(
    parameter int RAM_ADDR = 10,
    parameter int NB       = 8,
    parameter int PEAK_MAX = 8,
    parameter int PIXELS   = 4
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic                      start,
    input  logic [PEAK_MAX-1:0]       thresh,
    output logic [RAM_ADDR-1:0]       raddr,
    output logic                      rEnable,
    output logic                      readFlag,
    input  logic [PEAK_MAX-1:0]       counts,
    output logic                      busy,
    output logic [$clog2(PIXELS)-1:0] peakPixel,
    output logic [NB-1:0]             peakBin,
    output logic [PEAK_MAX-1:0]       peakCount,
    output logic                      peakFound,
    output logic                      peakValid,
    input  logic                      peakReady,
    output logic                      done
);
    localparam int PW = $clog2(PIXELS);
    localparam logic [PW-1:0] LAST_PIXEL = PW'(PIXELS - 1);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, OUT, DONE} state_t;
    state_t state, stateNext;

    logic [PW-1:0]       pixel;
    logic [NB-1:0]       bin;
    logic [PEAK_MAX-1:0] threshQ;

    // Read pipeline: stage 1 = SRAM data returning, stage 2 = registered count.
    logic                vld1, vld2;
    logic [NB-1:0]       bin1, bin2;
    logic [PEAK_MAX-1:0] countsQ;

    logic [PEAK_MAX-1:0] maxCount, nextCount;
    logic [NB-1:0]       maxBin, nextBin;
    logic                takeNew;

    // Bin 0 seeds the running max; later bins win only when strictly larger.
    assign takeNew   = vld2 && ((bin2 == '0) || (countsQ > maxCount));
    assign nextCount = takeNew ? countsQ : maxCount;
    assign nextBin   = takeNew ? bin2 : maxBin;

    always_ff @(posedge clk) begin
        if (!res) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
        stateNext = state;
        busy      = 1'b1;
        readFlag  = 1'b0;
        rEnable   = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) stateNext = READ;
            end
            READ: begin
                readFlag = 1'b1;
                rEnable  = 1'b0;
                if (bin == '1) stateNext = DRAIN;
            end
            DRAIN: stateNext = OUT;
            OUT: begin
                if (peakValid && peakReady)
                    stateNext = (pixel == LAST_PIXEL) ? DONE : READ;
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!res) begin
            pixel     <= '0;
            bin       <= '0;
            raddr     <= '0;
            threshQ   <= '0;
            vld1      <= 1'b0;
            vld2      <= 1'b0;
            bin1      <= '0;
            bin2      <= '0;
            countsQ   <= '0;
            maxCount  <= '0;
            maxBin    <= '0;
            peakValid <= 1'b0;
            peakPixel <= '0;
            peakBin   <= '0;
            peakCount <= '0;
            peakFound <= 1'b0;
        end else begin
            vld1     <= (state == READ);
            bin1     <= bin;
            vld2     <= vld1;
            bin2     <= bin1;
            if (vld1) countsQ <= counts;
            maxCount <= nextCount;
            maxBin   <= nextBin;

            case (state)
                IDLE: begin
                    if (start) begin
                        threshQ <= thresh;
                        pixel   <= '0;
                        bin     <= '0;
                        raddr   <= '0;
                    end
                end
                READ: begin
                    bin <= bin + NB'(1);
                    // raddr holds the last issued address so it never points past the array.
                    if (bin != '1) raddr <= raddr + RAM_ADDR'(1);
                end
                OUT: begin
                    // The last bin's count settles during the first OUT cycle.
                    if (!peakValid) begin
                        peakValid <= 1'b1;
                        peakPixel <= pixel;
                        peakBin   <= nextBin;
                        peakCount <= nextCount;
                        peakFound <= (nextCount >= threshQ);
                    end else if (peakReady) begin
                        peakValid <= 1'b0;
                        if (pixel != LAST_PIXEL) begin
                            pixel <= pixel + PW'(1);
                            raddr <= raddr + RAM_ADDR'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hist_peak_reader.sv
// Randomized bench for hist_peak_reader: an SRAM model feeds the sweep and a
// plain argmax reference predicts each pixel's peak, threshold flag and timing.
module tb_hist_peak_reader;
    localparam int RAM_ADDR = 10;
    localparam int NB       = 8;
    localparam int PEAK_MAX = 8;
    localparam int PIXELS   = 4;
    localparam int BINS     = 1 << NB;
    localparam int WORDS    = PIXELS * BINS;
    localparam int BUDGET   = 20000;

    logic                clk = 1'b0;
    logic                res = 1'b0;
    logic                start = 1'b0;
    logic [PEAK_MAX-1:0] thresh = '0;
    logic [RAM_ADDR-1:0] raddr;
    logic                rEnable, readFlag, busy;
    logic [PEAK_MAX-1:0] counts = '0;
    logic [1:0]          peakPixel;
    logic [NB-1:0]       peakBin;
    logic [PEAK_MAX-1:0] peakCount;
    logic                peakFound, peakValid, done;
    logic                peakReady = 1'b0;

    logic [7:0] mem [WORDS];
    int nCompared   = 0;
    int nMismatched = 0;
    int readCycles  = 0;
    int maxAddr     = 0;
    int doneCount   = 0;

    always #5 clk = ~clk;

    hist_peak_reader #(
        .RAM_ADDR(RAM_ADDR), .NB(NB), .PEAK_MAX(PEAK_MAX), .PIXELS(PIXELS)
    ) dut (
        .clk(clk), .res(res), .start(start), .thresh(thresh),
        .raddr(raddr), .rEnable(rEnable), .readFlag(readFlag), .counts(counts),
        .busy(busy), .peakPixel(peakPixel), .peakBin(peakBin), .peakCount(peakCount),
        .peakFound(peakFound), .peakValid(peakValid), .peakReady(peakReady), .done(done)
    );

    // SRAM port B: data for an address appears one cycle after it is issued.
    always @(posedge clk) if (readFlag && !rEnable) counts <= mem[raddr];

    always @(negedge clk) begin
        if (readFlag && !rEnable) begin
            readCycles++;
            if (int'(raddr) > maxAddr) maxAddr = int'(raddr);
        end
        if (done) doneCount++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void refPeak(input int p, output int bin, output int cnt);
        bin = 0;
        cnt = int'(mem[p*BINS]);
        for (int b = 1; b < BINS; b++)
            if (int'(mem[p*BINS+b]) > cnt) begin
                cnt = int'(mem[p*BINS+b]);
                bin = b;
            end
    endfunction

    task automatic checkResetValues(input string name);
        check({name, " raddr"}, raddr, 0);
        check({name, " rEnable"}, rEnable, 1);
        check({name, " readFlag"}, readFlag, 0);
        check({name, " busy"}, busy, 0);
        check({name, " peakValid"}, peakValid, 0);
        check({name, " done"}, done, 0);
        check({name, " peak outputs"}, {peakPixel, peakBin, peakCount, peakFound}, 0);
    endtask

    task automatic runSweep(input string name, input int th, input int rdyPct,
                            input int stallPix, input bit pokeStart);
        int expPix = 0;
        int since = -1;
        int budget = 0;
        int stallLeft = 0;
        int eb, ec;
        bit seen = 0;
        bit stable = 1;
        bit anyBusy = 0;
        logic [63:0] snap = '0;
        readCycles = 0;
        maxAddr = 0;
        doneCount = 0;
        @(negedge clk);
        start = 1'b1;
        thresh = th[7:0];
        while (expPix < PIXELS && budget < BUDGET) begin
            @(negedge clk);
            start = 1'b0;
            budget++;
            since++;
            if (pokeStart && budget == 100) begin
                start = 1'b1;
                thresh = ~th[7:0];
            end
            if (peakValid) begin
                if (!seen) begin
                    seen = 1;
                    check({name, " latency"}, since, BINS + 2);
                    refPeak(expPix, eb, ec);
                    check({name, " peakPixel"}, peakPixel, expPix);
                    check({name, " peakBin"}, peakBin, eb);
                    check({name, " peakCount"}, peakCount, ec);
                    check({name, " peakFound"}, peakFound, (ec >= th) ? 1 : 0);
                    snap = {raddr, peakPixel, peakBin, peakCount, peakFound};
                    stable = 1;
                    stallLeft = (expPix == stallPix) ? 20 : 0;
                end else if ({raddr, peakPixel, peakBin, peakCount, peakFound} !== snap || readFlag)
                    stable = 0;
                if (stallLeft > 0) begin
                    peakReady = 1'b0;
                    stallLeft--;
                end else
                    peakReady = ($urandom_range(0, 99) < rdyPct);
                if (peakReady) begin
                    check({name, " held while waiting"}, stable, 1);
                    expPix++;
                    seen = 0;
                    since = -1;
                end
            end else
                peakReady = ($urandom_range(0, 1) != 0);
        end
        check({name, " finished in budget"}, (budget < BUDGET) ? 1 : 0, 1);
        @(negedge clk);
        peakReady = 1'b0;
        check({name, " done pulse"}, done, 1);
        @(negedge clk);
        check({name, " done low after pulse"}, done, 0);
        check({name, " idle after done"}, busy, 0);
        for (int i = 0; i < (pokeStart ? 300 : 5); i++) begin
            @(negedge clk);
            if (busy || peakValid) anyBusy = 1;
        end
        check({name, " stays idle"}, anyBusy, 0);
        check({name, " done count"}, doneCount, 1);
        check({name, " read cycles"}, readCycles, WORDS);
        check({name, " max raddr"}, maxAddr, WORDS - 1);
    endtask

    initial begin
        int budget;
        for (int i = 0; i < WORDS; i++) mem[i] = 8'($urandom_range(0, 255));

        // Reset with start held high: start must not be taken.
        res = 1'b0;
        start = 1'b1;
        thresh = 8'd77;
        repeat (3) @(negedge clk);
        checkResetValues("power-on reset");
        res = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("idle after reset release", busy, 0);

        // Directed histograms: single spike, tie, saturated last bin.
        for (int i = 0; i < 3 * BINS; i++) mem[i] = 8'd0;
        mem[37] = 8'd200;
        mem[BINS + 12] = 8'd50;
        mem[BINS + 90] = 8'd50;
        mem[2*BINS + 255] = 8'd255;
        runSweep("directed th10", 10, 100, -1, 0);
        runSweep("directed th60 stall", 60, 100, 2, 1);

        // Reset in the middle of pixel 1's read phase, with a start alongside it.
        @(negedge clk);
        start = 1'b1;
        thresh = 8'd5;
        budget = 0;
        @(negedge clk);
        start = 1'b0;
        while (!(readFlag && int'(raddr) >= BINS + 40) && budget < 2000) begin
            peakReady = peakValid;
            @(negedge clk);
            budget++;
        end
        check("reached pixel 1 read", (budget < 2000) ? 1 : 0, 1);
        peakReady = 1'b0;
        res = 1'b0;
        start = 1'b1;
        @(negedge clk);
        checkResetValues("mid-sweep reset");
        res = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("idle after mid-sweep reset", busy, 0);
        runSweep("after reset", 5, 70, -1, 0);

        // All-zero histograms around the zero threshold.
        for (int i = 0; i < WORDS; i++) mem[i] = 8'd0;
        runSweep("zeros th0", 0, 60, -1, 0);
        runSweep("zeros th1", 1, 60, -1, 0);

        // Random contents: full range, heavy ties, saturated spikes.
        for (int s = 0; s < 6; s++) begin
            int mode = s % 3;
            int th = (s == 1) ? 255 : int'($urandom_range(0, 255));
            for (int i = 0; i < WORDS; i++) begin
                if (mode == 0) mem[i] = 8'($urandom_range(0, 255));
                else if (mode == 1) mem[i] = 8'($urandom_range(0, 3));
                else mem[i] = ($urandom_range(0, 31) == 0) ? 8'd255 : 8'($urandom_range(0, 254));
            end
            runSweep($sformatf("random %0d", s), th, 50, int'($urandom_range(0, PIXELS - 1)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/hist_peak_reader.md
HIST_PEAK_READER -- requirements
Module: hist_peak_reader

Interface
REQ-001 SHALL have parameter RAM_ADDR, default 10, histogram SRAM address width.
REQ-002 SHALL have parameter NB, default 8, bin-index width; BINS = 2^NB bins per pixel histogram.
REQ-003 SHALL have parameter PEAK_MAX, default 8, bin-count width.
REQ-004 SHALL have parameter PIXELS, default 4, pixel histograms stored back-to-back in SRAM; PIXELS*BINS <= 2^RAM_ADDR.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port res  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle request to sweep all pixel histograms.
REQ-008 SHALL have port thresh  input  PEAK_MAX  minimum count for a valid peak, sampled with start.
REQ-009 SHALL have port raddr  output  RAM_ADDR  SRAM port-B address (addrb).
REQ-010 SHALL have port rEnable  output  1  SRAM port-B enable, active-low (0 = read).
REQ-011 SHALL have port readFlag  output  1  SRAM port-B memory enable (meb), active-high.
REQ-012 SHALL have port counts  input  PEAK_MAX  SRAM port-B read data, valid one cycle after address.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port peakPixel  output  clog2(PIXELS)  pixel index of the presented result.
REQ-015 SHALL have port peakBin  output  NB  bin index of the maximum count.
REQ-016 SHALL have port peakCount  output  PEAK_MAX  maximum count.
REQ-017 SHALL have port peakFound  output  1  peakCount >= thresh.
REQ-018 SHALL have port peakValid  output  1  result valid; held until accepted.
REQ-019 SHALL have port peakReady  input  1  consumer accepts the result when sampled high with peakValid.
REQ-020 SHALL have port done  output  1  one-cycle pulse after the last pixel's result is accepted.

Function
REQ-021 SHALL implement states IDLE, READ, DRAIN, OUT and DONE.
REQ-022 IDLE SHALL go to READ on start=1, latching thresh and clearing the pixel index to 0; start SHALL be ignored in every other state.
REQ-023 READ SHALL assert readFlag=1 and rEnable=0, and drive raddr = pixel*BINS + bin, bin incrementing 0..BINS-1 with one address per cycle.
REQ-024 After address BINS-1 is issued, the FSM SHALL go to DRAIN for exactly one cycle, with readFlag=0 and rEnable=1.
REQ-025 The counts for address k SHALL be captured in the cycle after k is issued; bin 0 SHALL load the running max unconditionally.
REQ-026 A later bin SHALL replace the running max only if its count is strictly greater; ties SHALL keep the lowest bin index.
REQ-027 On DRAIN exit the FSM SHALL enter OUT, assert peakValid and drive peakPixel, peakBin, peakCount and peakFound, all stable while in OUT.
REQ-028 With peakReady=1 in the cycle READ is entered, peakValid SHALL first be high BINS+2 cycles after that entry.
REQ-029 OUT with peakReady=0 SHALL hold all outputs unchanged and issue no SRAM reads (backpressure stalls the sweep).
REQ-030 OUT with peakReady=1 SHALL drop peakValid next cycle, then go to READ for pixel+1, or to DONE if pixel = PIXELS-1.
REQ-031 DONE SHALL pulse done=1 for one cycle and then return to IDLE.
REQ-032 An all-zero histogram SHALL yield peakBin=0 and peakCount=0, with peakFound=1 only if thresh=0.
REQ-033 A count of all ones (saturated bin) SHALL compare correctly with no overflow; comparisons SHALL be unsigned.
REQ-034 raddr SHALL never exceed PIXELS*BINS-1.
REQ-035 The module SHALL never write the SRAM (read-only client of port B).

Reset
REQ-036 When res=0 at a clock edge, the FSM SHALL enter IDLE, including mid-sweep or in OUT.
REQ-037 Reset SHALL clear raddr=0, rEnable=1, readFlag=0, busy=0, peakValid=0, done=0, peakPixel=0, peakBin=0, peakCount=0, peakFound=0, and the running max and latched thresh to 0.
REQ-038 A start coinciding with res=0 SHALL be ignored.

Verification
REQ-039 Pixel 0 has a single 200 in bin 37 (others 0), thresh=10, peakReady=1 -> peakBin=37, peakCount=200, peakFound=1, peakValid first high 258 cycles after READ entry.
REQ-040 Pixel 1 has 50 in bins 12 and 90, thresh=60 -> peakBin=12, peakCount=50, peakFound=0.
REQ-041 Pixel 2 has 255 in bin 255 only -> peakBin=255, peakCount=255; raddr peaks at 767.
REQ-042 peakReady held 0 for 20 cycles in OUT -> outputs constant, readFlag=0, raddr unchanged; accepted on release.
REQ-043 res=0 during pixel 1 READ -> IDLE next cycle with all reset values; a new start sweeps from pixel 0.
REQ-044 Full 4-pixel sweep -> four accepted results, pixels 0..3 in order, then exactly one done pulse; a start while busy is ignored.
